// File: rtl/ram_pattern_gen_pkg.sv
// ram_pattern_gen_pkg: shared default widths, mode and FSM state encodings for ram_pattern_gen.
package ram_pattern_gen_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 32;
  localparam int COUNT_W_DEF = 16;
  localparam logic [1:0] MODE_WR = 2'd0;
  localparam logic [1:0] MODE_RD = 2'd1;
  localparam logic [1:0] MODE_WR_RD = 2'd2;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_GAP = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  // mode 3 behaves exactly like MODE_WR_RD
  function automatic logic has_readback(input logic [1:0] m);
    return m[1];
  endfunction
endpackage

// File: rtl/ram_pattern_gen_addr_gen.sv
// ram_pattern_addr_gen: address/data accumulator pair with clear, load and stride-step controls.
module ram_pattern_addr_gen #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_STRIDE = 4,
  parameter int DATA_STEP = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge CLK) begin
    if (!RESET_N || clear) begin
      addr <= '0;
      data <= '0;
    end else if (load) begin
      addr <= load_addr;
      data <= load_data;
    end else if (step) begin
      addr <= addr + ADDR_W'(ADDR_STRIDE);
      data <= data + DATA_W'(DATA_STEP);
    end
  end
endmodule

// File: rtl/ram_pattern_gen.sv
// ram_pattern_gen: write / read / write-then-readback RAM burst sequencer.
// Define RAM_PATTERN_CHECK_EN to add the read-data checker (data_in, error, err_count).
module ram_pattern_gen
  import ram_pattern_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int ADDR_STRIDE = 4,
  parameter int DATA_STEP = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [DATA_W-1:0]  data_seed,
  input  logic [COUNT_W-1:0] word_count,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  data_out,
  output logic               write,
  output logic               read,
  output logic               busy,
  output logic               done
`ifdef RAM_PATTERN_CHECK_EN
  ,
  input  logic [DATA_W-1:0]  data_in,
  output logic               error,
  output logic [COUNT_W-1:0] err_count
`endif
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  logic [2:0] state, nxt, end_st;
  logic [COUNT_W-1:0] i, cnt_q;
  logic [GAP_W-1:0] g;
  logic [1:0] mode_q, m;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic go, issue, is_wr, first, last;
  // done still high means the sequence has only just finished; start is ignored then
  assign go = state == S_IDLE && !done && start;
  assign m = go ? mode : mode_q;
  assign issue = (go && word_count != '0) || state == S_WRITE || state == S_READ;
  assign is_wr = (go && mode != MODE_RD) || state == S_WRITE;
  assign first = go || i == '0;
  assign last = go ? word_count == COUNT_W'(1) : cnt_q == i + COUNT_W'(1);
  assign end_st = !is_wr ? S_DRAIN : has_readback(m) ? (GAP_CYCLES == 0 ? S_READ : S_GAP) : S_DONE;
  assign nxt = state == S_IDLE ? (!go ? S_IDLE : word_count == '0 ? S_DONE : last ? end_st : is_wr ? S_WRITE : S_READ)
             : (state == S_WRITE || state == S_READ) ? (last ? end_st : state)
             : state == S_GAP ? (g == GAP_W'(GAP_CYCLES - 1) ? S_READ : S_GAP)
             : state == S_DRAIN ? S_DONE : S_IDLE;
  ram_pattern_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STRIDE(ADDR_STRIDE), .DATA_STEP(DATA_STEP)
  ) u_addr_gen (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .clear(state == S_DONE),
    .load(issue && first),
    .step(issue && !first),
    .load_addr(go ? base_addr : base_q),
    .load_data(go ? data_seed : seed_q),
    .addr(address),
    .data(data_out)
  );
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      i <= '0;
      g <= '0;
      mode_q <= MODE_WR;
      base_q <= '0;
      seed_q <= '0;
      cnt_q <= '0;
      write <= 1'b0;
      read <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      i <= issue && !last ? i + COUNT_W'(1) : '0;
      g <= state == S_GAP ? g + GAP_W'(1) : '0;
      if (go) begin
        mode_q <= mode;
        base_q <= base_addr;
        seed_q <= data_seed;
        cnt_q <= word_count;
      end
      write <= issue && is_wr;
      read <= issue && !is_wr;
      busy <= issue || state == S_GAP || state == S_DRAIN;
      done <= state == S_DONE;
    end
  end
`ifdef RAM_PATTERN_CHECK_EN
  logic rd_q;
  logic [DATA_W-1:0] exp_q;
  // RAM answers one cycle after the strobe, so compare against last cycle's expectation
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rd_q <= 1'b0;
      exp_q <= '0;
      error <= 1'b0;
      err_count <= '0;
    end else begin
      rd_q <= read;
      exp_q <= data_out;
      if (go) begin
        error <= 1'b0;
        err_count <= '0;
      end else if (rd_q && data_in != exp_q) begin
        error <= 1'b1;
        err_count <= &err_count ? err_count : err_count + COUNT_W'(1);
      end
    end
  end
`endif
endmodule

// File: tb/tb_ram_pattern_gen.sv
// tb_ram_pattern_gen: table-driven scoreboard bench for ram_pattern_gen (optionally with RAM_PATTERN_CHECK_EN).
module tb_ram_pattern_gen;
  localparam int AW = 64, DW = 32, CW = 16, GAP = 8;
  logic CLK = 1'b0, RESET_N = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] data_seed = '0;
  logic [CW-1:0] word_count = '0;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic write, read, busy, done;
`ifdef RAM_PATTERN_CHECK_EN
  logic [DW-1:0] data_in = '0;
  logic error;
  logic [CW-1:0] err_count;
  logic corrupt = 1'b0;
  logic [AW-1:0] bad_addr = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic err_at_done = 1'b0;
  logic [CW-1:0] cnt_at_done = '0;
  always @(posedge CLK) begin
    if (write) mem[address] = data_out;
    data_in <= (mem.exists(address) ? mem[address] : '0) ^ DW'(corrupt && read && address == bad_addr);
  end
`endif

  ram_pattern_gen dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .mode(mode),
    .base_addr(base_addr), .data_seed(data_seed), .word_count(word_count),
    .address(address), .data_out(data_out), .write(write), .read(read),
    .busy(busy), .done(done)
`ifdef RAM_PATTERN_CHECK_EN
    , .data_in(data_in), .error(error), .err_count(err_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] base;
    logic [31:0] seed;
    logic [15:0] cnt;
    int lat;
    int nw;
    int nr;
  } vec_t;
  typedef struct {
    logic [3:0]  flags;
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [3:0] f, input logic [63:0] a, input logic [31:0] d);
    exp_t e;
    e.flags = f;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endfunction

  // flags = {write, read, busy, done}, one record per visible cycle after the start edge
  function automatic void expect_run(input vec_t v);
    if (v.cnt == 0) begin
      push(4'b0000, '0, '0);
      push(4'b0001, '0, '0);
    end else begin
      if (v.mode != 2'd1)
        for (int k = 0; k < int'(v.cnt); k++) push(4'b1010, v.base + 64'(4 * k), v.seed + 32'(4 * k));
      if (v.mode[1])
        for (int k = 0; k < GAP; k++) push(4'b0010, '0, '0);
      if (v.mode != 2'd0) begin
        for (int k = 0; k < int'(v.cnt); k++) push(4'b0110, v.base + 64'(4 * k), v.seed + 32'(4 * k));
        push(4'b0010, '0, '0);
      end
      push(4'b0001, '0, '0);
    end
    push(4'b0000, '0, '0);
  endfunction

  task automatic go(input vec_t v);
    mode = v.mode;
    base_addr = v.base;
    data_seed = v.seed;
    word_count = v.cnt;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic consume(input vec_t v);
    int cyc = 0, nw = 0, nr = 0, lat = -1;
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      chk("flags", 64'({write, read, busy, done}), 64'(e.flags));
      chk("excl", 64'(write & read), 64'd0);
      if (e.flags[3] | e.flags[2]) begin
        chk("address", address, e.addr);
        chk("data", 64'(data_out), 64'(e.data));
      end
      nw += int'(write);
      nr += int'(read);
      if (done && lat < 0) begin
        lat = cyc;
`ifdef RAM_PATTERN_CHECK_EN
        err_at_done = error;
        cnt_at_done = err_count;
`endif
      end
      @(posedge CLK); #1;
    end
    chk("done_latency", 64'(lat), 64'(v.lat));
    chk("write_beats", 64'(nw), 64'(v.nw));
    chk("read_beats", 64'(nr), 64'(v.nr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v, v2;
    int seen;
    tbl[0] = '{2'd0, 64'd0, 32'd0, 16'd24, 25, 24, 0};
    tbl[1] = '{2'd2, 64'd512, 32'd0, 16'd24, 58, 24, 24};
    tbl[2] = '{2'd1, 64'h1000, 32'hDEAD_0000, 16'd5, 7, 0, 5};
    tbl[3] = '{2'd2, 64'h40, 32'd9, 16'd0, 2, 0, 0};
    tbl[4] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 16'd4, 5, 4, 0};
    tbl[5] = '{2'd3, 64'h40, 32'd7, 16'd1, 12, 1, 1};
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_flags", 64'({write, read, busy, done}), 64'd0);
    chk("rst_address", address, 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    for (int n = 0; n < 6; n++) begin
      expect_run(tbl[n]);
      go(tbl[n]);
      consume(tbl[n]);
    end
    // reset during the 10th write beat aborts without a done pulse
    go(tbl[0]);
    repeat (9) @(posedge CLK);
    #1;
    chk("beat10_write", 64'(write), 64'd1);
    chk("beat10_address", address, 64'd36);
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    chk("abort_flags", 64'({write, read, busy, done}), 64'd0);
    chk("abort_address", address, 64'd0);
    chk("abort_data", 64'(data_out), 64'd0);
    seen = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      seen += int'(done | busy | write | read);
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    expect_run(tbl[0]);
    go(tbl[0]);
    consume(tbl[0]);
    // start held while busy and during done is ignored, then accepted right after done
    v = '{2'd0, 64'h100, 32'h55, 16'd3, 4, 3, 0};
    v2 = '{2'd2, 64'h900, 32'h1000, 16'd7, 24, 7, 7};
    expect_run(v);
    go(v);
    mode = v2.mode;
    base_addr = v2.base;
    data_seed = v2.seed;
    word_count = v2.cnt;
    start = 1'b1;
    consume(v);
    start = 1'b0;
    expect_run(v2);
    consume(v2);
`ifdef RAM_PATTERN_CHECK_EN
    v = '{2'd2, 64'h2000, 32'h100, 16'd8, 26, 8, 8};
    bad_addr = 64'h2000 + 64'd20;
    corrupt = 1'b1;
    expect_run(v);
    go(v);
    consume(v);
    chk("error_at_done", 64'(err_at_done), 64'd1);
    chk("err_count_at_done", 64'(cnt_at_done), 64'd1);
    corrupt = 1'b0;
    expect_run(v);
    go(v);
    consume(v);
    chk("clean_error", 64'(err_at_done), 64'd0);
    chk("clean_err_count", 64'(cnt_at_done), 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
